// File: rtl/masked_path_arbiter.sv
// masked_path_arbiter: two requesters share one clear-mask-then-increment datapath
module masked_path_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         ct0,
    input  logic         ct1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic         busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    logic [1:0]   state;
    logic [W-1:0] in_r;
    logic [W-1:0] y;
    logic         ct_r;
    logic         sel;
    logic         last;
    logic         win;
    logic         winner;
    // arbitration is only open in IDLE and RESP; a tie goes to whoever did not win last
    always_comb begin
        win    = ((state == IDLE) || (state == RESP)) && (req0 || req1);
        winner = (req0 && req1) ? ~last : req1;
    end
    // sequencing: LOAD and CALC always advance, RESP either re-grants or idles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= win ? LOAD : (state == LOAD) ? CALC : (state == CALC) ? RESP : IDLE;
        end
    end
    // capture the winner's operands and remember it for tie-breaking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= 1'b0;
            last <= 1'b1;
            in_r <= '0;
            ct_r <= 1'b0;
        end else if (win) begin
            sel  <= winner;
            last <= winner;
            in_r <= winner ? x1 : x0;
            ct_r <= winner ? ct1 : ct0;
        end
    end
    // masking stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (state == LOAD) begin
            y <= ct_r ? '0 : in_r;
        end
    end
    // increment stage writes only the selected requester's result, wrapping modulo 2^W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0 <= '0;
            out1 <= '0;
        end else if (state == CALC) begin
            if (sel) out1 <= y + W'(1);
            else     out0 <= y + W'(1);
        end
    end
    // one-cycle grant and completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
        end else begin
            gnt0  <= win && !winner;
            gnt1  <= win && winner;
            done0 <= (state == CALC) && !sel;
            done1 <= (state == CALC) && sel;
        end
    end
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_masked_path_arbiter.sv
// tb_masked_path_arbiter: randomized scoreboard bench against a transaction-level model
module tb_masked_path_arbiter;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, ct0 = 1'b0, ct1 = 1'b0;
    logic [W-1:0] x0 = '0, x1 = '0;
    logic gnt0, gnt1, done0, done1, busy;
    logic [W-1:0] out0, out1;
    int total = 0;
    int bad = 0;

    masked_path_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .ct0(ct0), .ct1(ct1),
        .x0(x0), .x1(x1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .out0(out0), .out1(out1), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         who;
        logic [W-1:0] val;
        int           due;
    } ent_t;
    ent_t q[$];

    // reference model: the shared path is free when no operation is outstanding;
    // an operation occupies it for two further edges, then the result lands
    int           cyc;
    int           rem;
    logic         m_last;
    logic         p_who;
    logic [W-1:0] p_val;
    logic [W-1:0] m_out0, m_out1;
    logic         e_g0, e_g1, e_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; rem = 0; m_last = 1'b1; m_out0 = '0; m_out1 = '0;
            e_g0 = 1'b0; e_g1 = 1'b0; e_busy = 1'b0;
            q.delete();
        end else begin
            cyc++;
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (rem == 0) begin
                if (req0 || req1) begin
                    logic w;
                    logic [W-1:0] src;
                    w = (req0 && req1) ? !m_last : req1;
                    m_last = w;
                    src = (w ? ct1 : ct0) ? '0 : (w ? x1 : x0);
                    p_who = w;
                    p_val = W'((int'(src) + 1) % (1 << W));
                    q.push_back('{who: w, val: p_val, due: cyc + 2});
                    rem = 2;
                    e_busy = 1'b1;
                    if (w) e_g1 = 1'b1;
                    else   e_g0 = 1'b1;
                end else begin
                    e_busy = 1'b0;
                end
            end else begin
                rem--;
                if (rem == 0) begin
                    if (p_who) m_out1 = p_val;
                    else       m_out0 = p_val;
                end
            end
        end
    end

    // monitor: compare every visible output away from the active edge
    always @(negedge clk) begin
        logic [1:0] exp_d;
        chk("gnt0", gnt0, e_g0);
        chk("gnt1", gnt1, e_g1);
        chk("busy", busy, e_busy);
        chk("out0", out0, m_out0);
        chk("out1", out1, m_out1);
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_d = (q.size() > 0 && q[0].due == cyc) ? (q[0].who ? 2'b10 : 2'b01) : 2'b00;
        chk("done", {done1, done0}, exp_d);
        if (exp_d != 2'b00) begin
            ent_t e;
            e = q.pop_front();
            chk("done_val", e.who ? out1 : out0, e.val);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_gnt(input logic who);
        int k;
        for (k = 0; k < 20; k++) begin
            step(1);
            if (who ? gnt1 : gnt0) break;
        end
        chk(who ? "wait_gnt1" : "wait_gnt0", k < 20, 1);
    endtask

    initial begin
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_out0", out0, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        rst_n = 1'b1;

        req0 = 1'b1; x0 = 8'h05; ct0 = 1'b0;
        wait_gnt(1'b0);
        req0 = 1'b0;
        step(2);
        chk("basic_done0", done0, 1);
        chk("basic_out0", out0, 8'h06);
        chk("basic_out1", out1, 8'h00);
        step(3);

        req0 = 1'b1; x0 = 8'h05;
        wait_gnt(1'b0);
        req0 = 1'b0; x0 = 8'h7F;
        step(2);
        chk("late_x_out0", out0, 8'h06);
        step(2);

        req1 = 1'b1; ct1 = 1'b1; x1 = 8'hAA;
        wait_gnt(1'b1);
        req1 = 1'b0; ct1 = 1'b0;
        step(2);
        chk("mask_done1", done1, 1);
        chk("mask_out1", out1, 8'h01);
        step(2);

        req0 = 1'b1; x0 = 8'hFF;
        wait_gnt(1'b0);
        req0 = 1'b0;
        step(2);
        chk("wrap_done0", done0, 1);
        chk("wrap_out0", out0, 8'h00);
        step(2);

        rst_n = 1'b0;
        x0 = 8'h10; x1 = 8'h20; req0 = 1'b1; req1 = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("tie_first", {gnt1, gnt0}, 2'b01);
        step(3);
        chk("tie_second", {gnt1, gnt0}, 2'b10);
        step(3);
        chk("tie_third", {gnt1, gnt0}, 2'b01);
        step(6);
        req0 = 1'b0; req1 = 1'b0;
        step(5);
        chk("tie_out0", out0, 8'h11);
        chk("tie_out1", out1, 8'h21);

        req1 = 1'b1; x1 = 8'h33;
        wait_gnt(1'b1);
        rst_n = 1'b0;
        req1 = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_outs", {out1, out0}, 0);
        chk("abort_pulses", {done1, done0, gnt1, gnt0}, 0);
        step(3);
        chk("abort_nodone", {done1, done0}, 0);
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            step(1);
            if (req0 && gnt0) req0 = 1'($urandom % 2);
            else if (!req0) req0 = ($urandom % 3 == 0);
            else if ($urandom % 16 == 0) req0 = 1'b0;
            if (req1 && gnt1) req1 = 1'($urandom % 2);
            else if (!req1) req1 = ($urandom % 3 == 0);
            else if ($urandom % 16 == 0) req1 = 1'b0;
            if ($urandom % 2 == 0) x0 = W'($urandom);
            if ($urandom % 2 == 0) x1 = W'($urandom);
            ct0 = ($urandom % 4 == 0);
            ct1 = ($urandom % 4 == 0);
            if ($urandom % 600 == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/masked_path_arbiter.md
MASKED_PATH_ARBITER -- requirements
Module: masked_path_arbiter

Interface
REQ-001 Parameter: W, 8, data width of requester data and results (W >= 1).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req0, req1  input  1 each  level request from requester 0/1, held until gnt seen.
REQ-005 Port: ct0, ct1  input  1 each  clear control; 1 forces the masked value to zero.
REQ-006 Port: x0, x1  input  W each  operand data.
REQ-007 Port: gnt0, gnt1  output  1 each  registered one-cycle grant pulse.
REQ-008 Port: done0, done1  output  1 each  registered one-cycle completion pulse.
REQ-009 Port: out0, out1  output  W each  registered per-requester result, held between completions.
REQ-010 Port: busy  output  1  high whenever state != IDLE.

Function
REQ-011 Single shared datapath SHALL be time-multiplexed: in_r (W), ct_r (1), y (W), sel (1), last (1).
REQ-012 FSM states SHALL be IDLE, LOAD, CALC, RESP; state register encoding is free.
REQ-013 Arbitration SHALL happen at a rising edge in IDLE or RESP: exactly one req high -> that requester wins; both high -> requester != last wins.
REQ-014 On an arbitration win at edge E0: state<=LOAD, sel<=winner, last<=winner, in_r<=x_winner, ct_r<=ct_winner, gnt_winner<=1.
REQ-015 gnt SHALL be high only in the cycle after E0; both gnt never high together.
REQ-016 ct and x SHALL be sampled only at E0; later changes have no effect on the operation.
REQ-017 Edge E1 (LOAD): y <= ct_r ? 0 : in_r; state<=CALC.
REQ-018 Edge E2 (CALC): out_sel <= y + 1 modulo 2^W; done_sel<=1; state<=RESP; the other out register is unchanged.
REQ-019 Wrap-around: y = all-ones SHALL give out = 0, no carry out, no flag.
REQ-020 Edge E3 (RESP): done cleared; with any req high, arbitrate per REQ-013/014 (back-to-back grant), else state<=IDLE.
REQ-021 Latency: grant pulse in cycle after E0; done pulse and new out value in cycle after E2 (done 2 cycles after gnt).
REQ-022 Throughput: one operation per 3 cycles under continuous requests, alternating strictly when both held.
REQ-023 In IDLE with no req: no state change, outputs hold.
REQ-024 req dropped before arbitration: no grant, no side effects.
REQ-025 Requests in LOAD or CALC SHALL be ignored until RESP edge.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, gnt0/1=0, done0/1=0, out0/out1=0, busy=0, in_r=0, ct_r=0, y=0, sel=0, last=1 (requester 0 wins first tie).
REQ-027 Reset mid-operation SHALL abort it: no done pulse, out registers read 0.
REQ-028 First arbitration SHALL occur at the first rising edge with rst_n high.

Verification
REQ-029 Reset, then req0=1, x0=8'h05, ct0=0 -> gnt0 one cycle; done0 two cycles later with out0=8'h06; out1=0.
REQ-030 req1=1, ct1=1, x1=8'hAA -> done1 with out1=8'h01 (masked zero plus one).
REQ-031 req0, req1 both held from reset, x0=8'h10, x1=8'h20 -> grants 0,1,0,1 every 3 cycles; out0=8'h11, out1=8'h21.
REQ-032 req0=1, x0=8'hFF, ct0=0 -> out0=8'h00 (wrap), done0 asserted.
REQ-033 rst_n low in cycle after gnt1 -> no done1 pulse; all outputs 0; busy=0.
REQ-034 x0 changed from 8'h05 to 8'h7F in cycle after gnt0 -> out0 still 8'h06.
